// File: rtl/adc_capture_gate.sv
// adc_capture_gate: triggered fixed-length AXI4-Stream capture window from a non-stallable ADC stream
module adc_capture_gate #(
  parameter int DATA_WIDTH = 128,
  parameter int NBEATS = 2048,
  parameter int HOLDOFF = 0
) (
  input logic aclk,
  input logic reset_i,
  input logic capture_i,
  input logic [DATA_WIDTH-1:0] s_axis_tdata,
  input logic s_axis_tvalid,
  output logic s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic m_axis_tvalid,
  input logic m_axis_tready,
  output logic m_axis_tlast,
  output logic busy_o,
  output logic done_o,
  output logic overflow_o
);
  localparam int CW = $clog2(NBEATS + 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(NBEATS - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);
  typedef enum logic [1:0] {IDLE, HOLD, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [CW-1:0] beat_cnt;
  logic [15:0] hold_cnt;
  logic [DATA_WIDTH:0] head, tail;
  logic [1:0] fill, free_slot;
  logic start, pop, push_req, push, last_push;
  assign start = state == IDLE && capture_i;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign push_req = state == RUN && s_axis_tvalid;
  assign push = push_req && (fill != 2'd2 || pop);
  assign last_push = push && beat_cnt == BEAT_LAST;
  assign free_slot = fill - {1'b0, pop};
  assign s_axis_tready = !reset_i;
  assign m_axis_tvalid = fill != 2'd0;
  assign m_axis_tdata = head[DATA_WIDTH-1:0];
  assign m_axis_tlast = m_axis_tvalid && head[DATA_WIDTH];
  assign busy_o = state != IDLE;
  // capture sequencing: arm, skip hold-off beats, capture, drain the tlast beat
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (capture_i) state_n = HOLDOFF > 0 ? HOLD : RUN;
      HOLD: if (s_axis_tvalid && hold_cnt == HOLD_LAST) state_n = RUN;
      RUN: if (last_push) state_n = FLUSH;
      FLUSH: if (pop && m_axis_tlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge aclk or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_n;
  // beat/hold counters, sticky drop flag and completion pulse
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      beat_cnt <= '0;
      hold_cnt <= '0;
      overflow_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= state == FLUSH && pop && m_axis_tlast;
      if (start) begin
        beat_cnt <= '0;
        hold_cnt <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (state == HOLD && s_axis_tvalid) hold_cnt <= hold_cnt + 16'd1;
        if (push) beat_cnt <= beat_cnt + CW'(1);
        if (push_req && !push) overflow_o <= 1'b1;
      end
    end
  end
  // two-entry FIFO: head drives the output, a push lands in the first slot left free after any pop
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      fill <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      fill <= fill + {1'b0, push} - {1'b0, pop};
      if (pop && fill == 2'd2) head <= tail;
      if (push && free_slot == 2'd0) head <= {last_push, s_axis_tdata};
      if (push && free_slot == 2'd1) tail <= {last_push, s_axis_tdata};
    end
  end
endmodule

// File: tb/tb_adc_capture_gate.sv
// tb_adc_capture_gate: randomized capture scenarios checked against a queue-based model of the capture window
module tb_adc_capture_gate;
  localparam int DW = 128;
  localparam int NB = 8;
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic rst, cap0, cap4, s_tvalid, m_tready;
  logic [DW-1:0] s_tdata;
  logic s_tready0, m_tvalid0, m_tlast0, busy0, done0, ovf0;
  logic s_tready4, m_tvalid4, m_tlast4, busy4, done4, ovf4;
  logic [DW-1:0] m_tdata0, m_tdata4;
  int n_chk = 0, n_fail = 0, cyc = 0, pv = 100;
  logic [31:0] ramp = 0;
  logic [DW-1:0] in_q0[$], in_q4[$];
  logic [DW:0] out_q0[$], out_q4[$];
  bit col0 = 0, col4 = 0;
  int dn0 = 0, dn4 = 0, hs_cyc0 = 0, hs_cyc4 = 0;

  adc_capture_gate #(.DATA_WIDTH(DW), .NBEATS(NB), .HOLDOFF(0)) u0 (
    .aclk(aclk), .reset_i(rst), .capture_i(cap0), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready0), .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast0), .busy_o(busy0), .done_o(done0), .overflow_o(ovf0));
  adc_capture_gate #(.DATA_WIDTH(DW), .NBEATS(NB), .HOLDOFF(4)) u4 (
    .aclk(aclk), .reset_i(rst), .capture_i(cap4), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready4), .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast4), .busy_o(busy4), .done_o(done4), .overflow_o(ovf4));

  // monitor: an accepted trigger opens a window that records every later valid input beat and every output handshake
  always @(negedge aclk) begin
    if (col0 && s_tvalid) in_q0.push_back(s_tdata);
    if (col4 && s_tvalid) in_q4.push_back(s_tdata);
    if (m_tvalid0 && m_tready) begin
      out_q0.push_back({m_tlast0, m_tdata0});
      if (m_tlast0) hs_cyc0 = cyc;
    end
    if (m_tvalid4 && m_tready) begin
      out_q4.push_back({m_tlast4, m_tdata4});
      if (m_tlast4) hs_cyc4 = cyc;
    end
    if (cap0 && !busy0 && !rst) begin
      col0 = 1;
      in_q0.delete();
      out_q0.delete();
    end
    if (cap4 && !busy4 && !rst) begin
      col4 = 1;
      in_q4.delete();
      out_q4.delete();
    end
    if (done0) dn0++;
    if (done4) dn4++;
  end

  task automatic tick;
    @(posedge aclk);
    #1;
    cyc++;
    ramp++;
    s_tdata = {4{ramp}};
    s_tvalid = $urandom_range(99) < pv;
  endtask

  task automatic trig0(output logic [31:0] v);
    tick;
    cap0 = 1;
    v = ramp;
    tick;
    cap0 = 0;
  endtask

  task automatic wait_done(input bit which, output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick;
      ok = which ? done4 : done0;
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    #3 rst = 1;
    #1;
    n_chk++;
    if ({m_tvalid0, m_tlast0, busy0, done0, ovf0, s_tready0} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags_u0: got %b expected 000000", {m_tvalid0, m_tlast0, busy0, done0, ovf0, s_tready0});
    end
    n_chk++;
    if ({m_tvalid4, m_tlast4, busy4, done4, ovf4, s_tready4} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags_u4: got %b expected 000000", {m_tvalid4, m_tlast4, busy4, done4, ovf4, s_tready4});
    end
    n_chk++;
    if (m_tdata0 !== '0 || m_tdata4 !== '0) begin
      n_fail++;
      $display("FAIL reset_tdata: got %h / %h expected 0", m_tdata0, m_tdata4);
    end
    repeat (3) tick;
    rst = 0;
    tick;
    n_chk++;
    if ({s_tready0, s_tready4} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_tready: got %b expected 11", {s_tready0, s_tready4});
    end
    repeat (4) tick;
    n_chk++;
    if ({m_tvalid0, m_tvalid4, busy0, busy4} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle_no_beat: got %b expected 0000", {m_tvalid0, m_tvalid4, busy0, busy4});
    end
  endtask

  task automatic test_basic;
    bit ok;
    pv = 100;
    m_tready = 1;
    ramp = 9;
    tick;
    cap0 = 1;
    tick;
    cap0 = 0;
    n_chk++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_rise: got %b expected 1", busy0);
    end
    wait_done(0, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done_timeout: got no done expected done");
    end
    n_chk++;
    if (cyc != hs_cyc0 + 1 || busy0 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_timing: got cyc %0d busy %b ovf %b expected cyc %0d busy 0 ovf 0", cyc, busy0, ovf0, hs_cyc0 + 1);
    end
    n_chk++;
    if (out_q0.size() != NB) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected %0d", out_q0.size(), NB);
    end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (i >= out_q0.size() || out_q0[i] !== {i == NB - 1, {4{32'(11 + i)}}}) begin
        n_fail++;
        $display("FAIL basic_beat[%0d]: got %h expected %h", i, i < out_q0.size() ? out_q0[i] : 'x, {i == NB - 1, {4{32'(11 + i)}}});
      end
    end
    tick;
    n_chk++;
    if (done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got %b expected 0", done0);
    end
  endtask

  task automatic test_holdoff;
    bit ok;
    ramp = 9;
    tick;
    cap4 = 1;
    tick;
    cap4 = 0;
    wait_done(1, ok);
    n_chk++;
    if (!ok || out_q4.size() != NB || cyc != hs_cyc4 + 1) begin
      n_fail++;
      $display("FAIL holdoff_count: got ok %b n %0d expected ok 1 n %0d", ok, out_q4.size(), NB);
    end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (i >= out_q4.size() || out_q4[i] !== {i == NB - 1, {4{32'(15 + i)}}}) begin
        n_fail++;
        $display("FAIL holdoff_beat[%0d]: got %h expected %h", i, i < out_q4.size() ? out_q4[i] : 'x, {i == NB - 1, {4{32'(15 + i)}}});
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok = 0, stalled = 0;
    logic [31:0] v;
    trig0(v);
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!stalled && out_q0.size() >= 2) begin
        m_tready = 0;
        repeat (5) tick;
        m_tready = 1;
        stalled = 1;
      end
      tick;
      ok = done0;
    end
    n_chk++;
    if (!ok || ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overflow: got ok %b ovf %b expected ok 1 ovf 1", ok, ovf0);
    end
    n_chk++;
    if (out_q0.size() != NB) begin
      n_fail++;
      $display("FAIL bp_count: got %0d expected %0d", out_q0.size(), NB);
    end
    for (int i = 0; i < out_q0.size(); i++) begin
      n_chk++;
      if (out_q0[i][DW] !== (i == NB - 1) || out_q0[i][DW-1:0] !== {4{out_q0[i][31:0]}} ||
          (i == 0 ? out_q0[i][31:0] !== v + 1 : out_q0[i][31:0] <= out_q0[i-1][31:0])) begin
        n_fail++;
        $display("FAIL bp_beat[%0d]: got %h expected increasing lane-consistent data, tlast only on beat %0d", i, out_q0[i], NB - 1);
      end
    end
    n_chk++;
    if (out_q0.size() != NB || out_q0[NB-1][31:0] - out_q0[0][31:0] <= NB - 1) begin
      n_fail++;
      $display("FAIL bp_gap: got span %0d expected > %0d", out_q0.size() == NB ? out_q0[NB-1][31:0] - out_q0[0][31:0] : 0, NB - 1);
    end
    repeat (3) tick;
    n_chk++;
    if (ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_sticky: got %b expected 1", ovf0);
    end
  endtask

  task automatic test_retrigger;
    bit ok;
    int d;
    logic [31:0] v;
    d = dn0;
    trig0(v);
    n_chk++;
    if (ovf0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_clear: got ovf %b busy %b expected ovf 0 busy 1", ovf0, busy0);
    end
    repeat (3) tick;
    cap0 = 1;
    tick;
    cap0 = 0;
    wait_done(0, ok);
    tick;
    n_chk++;
    if (!ok || out_q0.size() != NB || dn0 != d + 1) begin
      n_fail++;
      $display("FAIL retrig_count: got ok %b n %0d dones %0d expected ok 1 n %0d dones %0d", ok, out_q0.size(), dn0 - d, NB, 1);
    end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (i >= out_q0.size() || out_q0[i] !== {i == NB - 1, {4{v + 32'(1 + i)}}}) begin
        n_fail++;
        $display("FAIL retrig_beat[%0d]: got %h expected %h", i, i < out_q0.size() ? out_q0[i] : 'x, {i == NB - 1, {4{v + 32'(1 + i)}}});
      end
    end
    repeat (5) tick;
    n_chk++;
    if (busy0 !== 1'b0 || dn0 != d + 1) begin
      n_fail++;
      $display("FAIL retrig_no_rearm: got busy %b dones %0d expected busy 0 dones 1", busy0, dn0 - d);
    end
  endtask

  task automatic test_random;
    bit ok0, ok4;
    for (int r = 0; r < 4; r++) begin
      pv = $urandom_range(30, 90);
      ok0 = 0;
      ok4 = 0;
      tick;
      cap0 = 1;
      cap4 = 1;
      tick;
      cap0 = 0;
      cap4 = 0;
      for (int i = 0; i < 600 && !(ok0 && ok4); i++) begin
        tick;
        ok0 |= done0;
        ok4 |= done4;
      end
      n_chk++;
      if (!ok0 || !ok4 || out_q0.size() != NB || out_q4.size() != NB) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: got done %b%b n %0d/%0d expected done 11 n %0d", r, ok0, ok4, out_q0.size(), out_q4.size(), NB);
      end
      for (int i = 0; i < NB; i++) begin
        n_chk++;
        if (i >= out_q0.size() || i >= in_q0.size() || out_q0[i] !== {i == NB - 1, in_q0[i]}) begin
          n_fail++;
          $display("FAIL rand_u0_beat[%0d.%0d]: got %h expected %h", r, i, i < out_q0.size() ? out_q0[i] : 'x, i < in_q0.size() ? {i == NB - 1, in_q0[i]} : 'x);
        end
        n_chk++;
        if (i >= out_q4.size() || i + 4 >= in_q4.size() || out_q4[i] !== {i == NB - 1, in_q4[i+4]}) begin
          n_fail++;
          $display("FAIL rand_u4_beat[%0d.%0d]: got %h expected %h", r, i, i < out_q4.size() ? out_q4[i] : 'x, i + 4 < in_q4.size() ? {i == NB - 1, in_q4[i+4]} : 'x);
        end
      end
    end
    pv = 100;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d, tl;
    logic [31:0] v;
    trig0(v);
    for (int i = 0; i < 50 && out_q0.size() < 3; i++) tick;
    @(negedge aclk);
    rst = 1;
    #1;
    d = dn0;
    n_chk++;
    if ({m_tvalid0, m_tlast0, busy0, done0, ovf0, s_tready0} !== 6'b0 || m_tdata0 !== '0) begin
      n_fail++;
      $display("FAIL rmid_clear: got %b data %h expected 000000 data 0", {m_tvalid0, m_tlast0, busy0, done0, ovf0, s_tready0}, m_tdata0);
    end
    repeat (3) tick;
    rst = 0;
    repeat (4) tick;
    tl = 0;
    foreach (out_q0[i]) tl += int'(out_q0[i][DW]);
    n_chk++;
    if (tl != 0 || out_q0.size() < 3 || out_q0.size() >= NB || dn0 != d || m_tvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_aborted: got tlasts %0d beats %0d dones %0d tvalid %b expected 0, 3..%0d, 0, 0", tl, out_q0.size(), dn0 - d, m_tvalid0, NB - 1);
    end
    trig0(v);
    wait_done(0, ok);
    tick;
    n_chk++;
    if (!ok || out_q0.size() != NB || dn0 != d + 1) begin
      n_fail++;
      $display("FAIL rmid_recapture: got ok %b n %0d dones %0d expected ok 1 n %0d dones 1", ok, out_q0.size(), dn0 - d, NB);
    end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (i >= out_q0.size() || out_q0[i] !== {i == NB - 1, {4{v + 32'(1 + i)}}}) begin
        n_fail++;
        $display("FAIL rmid_beat[%0d]: got %h expected %h", i, i < out_q0.size() ? out_q0[i] : 'x, {i == NB - 1, {4{v + 32'(1 + i)}}});
      end
    end
  endtask

  initial begin
    rst = 0;
    cap0 = 0;
    cap4 = 0;
    m_tready = 1;
    s_tvalid = 0;
    s_tdata = '0;
    test_reset;
    test_basic;
    test_holdoff;
    test_backpressure;
    test_retrigger;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1);
  end
endmodule

// File: doc/adc_capture_gate.md
# adc_capture_gate

Single-clock AXI4-Stream capture gate between one 128-bit RFDC ADC output stream and one buffer input stream (buf0_/buf1_) of the PS capture buffers. On a capture request it waits a programmable hold-off, forwards exactly NBEATS accepted ADC beats, marks the last beat with tlast, then returns to idle. A two-entry output FIFO absorbs buffer back-pressure. ADC beats that cannot be stored are dropped and flagged, because the ADC stream is never stalled.

## Interface
Parameters:
- DATA_WIDTH, 128, stream width (8 × 16-bit samples).
- NBEATS, 2048, beats per capture; must be ≥ 1. Counter width is clog2(NBEATS+1).
- HOLDOFF, 0, input valid beats skipped after trigger before capture; range 0..65535.

Ports:
- aclk  in  1  stream clock; all I/O is synchronous to it.
- reset_i  in  1  reset, asynchronous assert, active-high.
- capture_i  in  1  capture request, level sampled, already synchronous to aclk.
- s_axis_tdata  in  DATA_WIDTH  ADC beat.
- s_axis_tvalid  in  1  ADC beat valid.
- s_axis_tready  out  1  constant 1 when out of reset; 0 while reset_i is high.
- m_axis_tdata  out  DATA_WIDTH  beat to buffer.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  buffer ready.
- m_axis_tlast  out  1  high on the final beat of a capture.
- busy_o  out  1  capture in progress.
- done_o  out  1  one-cycle pulse at capture completion.
- overflow_o  out  1  sticky flag: at least one beat was dropped in the current or last capture.

Decided: one clock; reset is asynchronous and active-high; clock `aclk`, reset `reset_i`.

## Operation
- The state machine has four states: IDLE, HOLD, RUN, FLUSH.
- **IDLE:** capture_i=1 moves to HOLD if HOLDOFF>0, else straight to RUN. The move clears overflow_o, the beat counter and the hold counter. busy_o rises the same edge.
- **HOLD:** counts s_axis_tvalid beats without storing them. When the count reaches HOLDOFF, moves to RUN. The beat that completes the count is discarded; the next valid beat is the first one captured.
- **RUN:** each s_axis_tvalid beat is pushed into the FIFO if it is not full. A pushed beat increments the counter. A beat that arrives while the FIFO is full is dropped, sets overflow_o and is not counted.
  - The push that makes the count equal NBEATS carries tlast=1 and moves the machine to FLUSH.
  - The capture window therefore always delivers exactly NBEATS beats.
- **FLUSH:** no pushes. When the tlast beat is handshaken (tvalid & tready & tlast), the machine moves to IDLE. busy_o falls and done_o pulses for 1 cycle on the following cycle.
- capture_i is ignored outside IDLE. There is no queued request; a held-high capture_i re-arms in the first IDLE cycle.
- **FIFO:** 2 entries, registered output. A push and a pop in the same cycle are allowed when the FIFO is full: the pop frees a slot, so the push succeeds. The FIFO is never written outside RUN.
- m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
- tlast is 0 on every beat except the NBEATS-th.

## Timing
- **Reset values:** m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy_o=0, done_o=0, overflow_o=0, s_axis_tready=0, FIFO empty, state IDLE.
- **Reset mid-capture:** the FIFO is emptied immediately, no tlast is emitted and no done_o pulses. Capture resumes only after reset_i falls and a new capture_i arrives.
- **Trigger timing:** capture_i is sampled high at edge T. With HOLDOFF=0, the first captured beat is the valid beat present at edge T+1.
- **Latency:** a beat pushed at edge k is presented on m_axis at k+1. With tready held at 1 the throughput is 1 beat/cycle and nothing is dropped.
- **done timing:** done_o is high during the cycle after the tlast handshake edge. busy_o is 0 in that same cycle.
- **NBEATS=1:** the first pushed beat carries tlast.
- **Simultaneous events:** if a drop and the final push fall in the same capture, overflow_o stays set through done_o until the next trigger.

## Test plan
- **Reset check:** assert reset_i asynchronously mid-cycle. All outputs reach their reset values without a clock edge, and no m_axis beat appears until a new capture.
- **Basic capture** (NBEATS=8, HOLDOFF=0, tready=1, ramp tdata 0,1,2… one per cycle, trigger sampled while input=10): exactly 8 output beats 11..18, tlast only on 18, done_o pulse 1 cycle after, overflow_o=0.
- **Hold-off** (HOLDOFF=4, same ramp, trigger at 10): output beats 15..22, 8 beats, tlast on 22.
- **Back-pressure** (NBEATS=8, tready=0 for 5 cycles after the 2nd output beat): overflow_o=1, still exactly 8 beats with tlast on the 8th, data strictly increasing with gaps at the dropped beats, no duplicates.
- **Re-trigger:** capture_i pulsed while busy has no effect. A second capture after done_o clears overflow_o and yields 8 fresh beats.
- **Reset mid-RUN:** reset asserted after 3 output beats. Outputs clear, no tlast, no done_o; a subsequent capture delivers a full 8 beats.
